// File: rtl/add_mul_comp_sub_4_bit_issue.sv
// Issue/capture stage for the 4-bit arithmetic unit: operand FIFO, settle timer, tagged result register.
// Ports: in_* request stream, dut_a/dut_b/dut_result unit hookup, out_* result stream, fifo_level occupancy.
module add_mul_comp_sub_4_bit_issue #(
  parameter int DEPTH         = 4,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [3:0]               dut_a,
  output logic [3:0]               dut_b,
  input  logic [7:0]               dut_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end

  typedef struct packed {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nx;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic             push;
  logic             pop;
  logic             capture;
  logic             done;

  // in_ready looks only at the registered count, so a pop never
  // opens the FIFO to a push within the same cycle.
  assign in_ready   = (count != (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_level = count;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CW'(1)) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          done = 1'b1;
          if (count != '0) begin
            pop      = 1'b1;
            state_nx = SETTLE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b, tag: in_tag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_a      <= '0;
      dut_b      <= '0;
      tag_q      <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (pop) begin
        dut_a <= head.a;
        dut_b <= head.b;
        tag_q <= head.tag;
        cnt   <= CW'(SETTLE_CYCLES);
      end else if (state == SETTLE) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        out_result <= dut_result;
        out_tag    <= tag_q;
        out_valid  <= 1'b1;
      end else if (done) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/add_mul_comp_sub_4_bit_issue.md
# add_mul_comp_sub_4_bit_issue

Sequential issue/capture stage wrapped around the 4-bit combinational arithmetic unit (`add_mul_comp_sub_4_bit`). It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It drives each pair onto the unit's `a`/`b` inputs, waits a programmable settle time, then captures the 8-bit `Result` into a registered, tagged output stream with backpressure. It lets the combinational unit sit in a clocked, stallable datapath.

## Interface
- `DEPTH`, default 4: input FIFO entries; power of two, at least 2.
- `TAG_W`, default 4: width of the request tag carried with each operation.
- `SETTLE_CYCLES`, default 1: cycles the operands are held on the unit before capture; at least 1 (0 is illegal, and an assertion fires at elaboration).
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low; assertion clears all state immediately, deassertion is synchronous to `clk` externally.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: FIFO can accept.
- `in_a`, in, 4: operand a.
- `in_b`, in, 4: operand b.
- `in_tag`, in, TAG_W: request tag.
- `dut_a`, out, 4: registered operand to unit port `a`.
- `dut_b`, out, 4: registered operand to unit port `b`.
- `dut_result`, in, 8: unit `Result` (combinational from `dut_a`/`dut_b`).
- `out_valid`, out, 1: captured result valid.
- `out_ready`, in, 1: consumer accepts.
- `out_result`, out, 8: captured result.
- `out_tag`, out, TAG_W: tag of the captured result.
- `fifo_level`, out, clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - Circular buffer, DEPTH entries of {a, b, tag}, with registered wrapping read/write pointers and a count.
  - Push on `in_valid && in_ready`; pop on issue.
  - `in_ready = (count != DEPTH)`, driven from registered count only. There is no combinational path from pop to `in_ready`, so when full and popping in the same cycle, `in_ready` stays 0.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- **FSM states: IDLE, SETTLE, HOLD**
  - **IDLE:** if count != 0, pop the head into `dut_a`/`dut_b`/tag register, load the settle counter with SETTLE_CYCLES, and go to SETTLE. Otherwise stay. `dut_a`/`dut_b` keep their last values.
  - **SETTLE:** decrement the counter each cycle. When the counter equals 1:
    - capture `dut_result` into `out_result` and the tag into `out_tag`;
    - set `out_valid`;
    - go to HOLD.
  - **HOLD:**
    - `out_valid = 1`; `out_result` and `out_tag` are stable until the handshake.
    - On `out_ready` with count != 0: pop the next entry, reload the counter, go to SETTLE, and clear `out_valid`. This is a back-to-back issue.
    - On `out_ready` with count == 0: clear `out_valid` and go to IDLE.
    - Without `out_ready`: stay. The FIFO keeps accepting until full.
- An entry pushed in the same cycle the FIFO is empty cannot be popped that cycle. Pop uses registered count.
- **Reset values:**
  - `in_ready` 1;
  - `dut_a`, `dut_b` 0;
  - `out_valid` 0;
  - `out_result` 0;
  - `out_tag` 0;
  - `fifo_level` 0;
  - FSM IDLE;
  - pointers and counter 0.
- **Reset mid-operation:** the in-flight operation and all buffered entries are discarded. No output is produced for them.

## Timing
- **Latency:** input handshake at edge t, FIFO previously empty, FSM IDLE.
  - Pop at t+1; `dut_a`/`dut_b` are valid after t+1.
  - Capture at t+1+SETTLE_CYCLES; `out_valid` is high in the following cycle.
  - Total is SETTLE_CYCLES+1 cycles from the input handshake to `out_valid`.
- **Throughput:** with `out_ready` tied high and the FIFO non-empty, one result every SETTLE_CYCLES+1 cycles (one HOLD cycle plus SETTLE_CYCLES).
- `dut_a`/`dut_b` change only on a pop edge. They are stable for at least SETTLE_CYCLES full cycles before capture.
- `out_result`, `out_tag` and `out_valid` are registered. No input-to-output combinational path exists except `dut_result` to the capture register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SETTLE with 3 entries queued.
  - Required: immediately `out_valid`=0, `fifo_level`=0, `dut_a`=`dut_b`=0, `in_ready`=1.
  - Required: no output after release.
- **Single op, loopback model:** bench sets `dut_result={dut_a,dut_b}`, SETTLE_CYCLES=1. Push a=4'hA, b=4'h3, tag=5 at edge t.
  - Required: `out_valid` rises after edge t+2 with `out_result`=8'hA3 and `out_tag`=5.
- **Back-to-back, `out_ready`=1:** push tags 0..3 on consecutive cycles, SETTLE_CYCLES=2.
  - Required: results appear in tag order 0,1,2,3, spaced 3 cycles apart.
  - Required: `fifo_level` peaks at 3.
- **Full FIFO, DEPTH=4:** hold `out_ready`=0 and push 6 requests.
  - Required: 1 issued into HOLD, 4 buffered, then `in_ready`=0.
  - Required: the 6th is held off until a HOLD handshake frees an entry.
  - Required: no entry is lost or duplicated.
- **Wrap-around:** push/pop 10 ops with a random `out_ready` pattern.
  - Required: all 10 results in order, each matching the loopback model, with pointers wrapping correctly.
- **Simultaneous push and pop while full:** `in_ready` stays 0 on that cycle, `fifo_level` goes to 3 after the pop, and `in_ready`=1 on the next cycle.
